// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between icache (ID 0) and dcache (ID 1),
// with line-granular read-after-write holdoff and rid-based return routing.
module axi_rd_arbiter #(
  parameter int LINE_OFF    = 4,
  parameter int BURST_BEATS = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        icache_rd_req,
  input  logic [2:0]  icache_rd_type,
  input  logic [31:0] icache_rd_addr,
  output logic        icache_rd_rdy,
  output logic        icache_ret_valid,
  output logic        icache_ret_last,
  output logic [31:0] icache_ret_data,
  input  logic        dcache_rd_req,
  input  logic [2:0]  dcache_rd_type,
  input  logic [31:0] dcache_rd_addr,
  output logic        dcache_rd_rdy,
  output logic        dcache_ret_valid,
  output logic        dcache_ret_last,
  output logic [31:0] dcache_ret_data,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic        rd_err,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_AR_SEND = 1'b1;

  logic [0:0]  state;
  logic [1:0]  busy;
  logic [1:0]  busy_nxt;
  logic        last_grant;
  logic        hazard_i, hazard_d;
  logic        elig_i, elig_d;
  logic        grant;
  logic        ar_hs, r_hs;

  logic        ret_vld_p1;
  logic        ret_id_p1;
  logic        ret_last_p1;
  logic [31:0] ret_data_p1;

  // Only rid[0] selects the owner; the low write-address bits are below line granularity.
  logic        addr_unused;
  assign addr_unused = ^{rid[3:1], wr_addr[LINE_OFF-1:0]};

  function automatic logic [7:0] burst_len(input logic [2:0] rd_type);
    return (rd_type == 3'b100) ? 8'(BURST_BEATS - 1) : 8'd0;
  endfunction

  always_comb begin
    hazard_i = wr_pending & (wr_addr[31:LINE_OFF] == icache_rd_addr[31:LINE_OFF]);
    hazard_d = wr_pending & (wr_addr[31:LINE_OFF] == dcache_rd_addr[31:LINE_OFF]);
    elig_i   = icache_rd_req & ~busy[0] & ~hazard_i;
    elig_d   = dcache_rd_req & ~busy[1] & ~hazard_d;
    if (elig_i & elig_d) grant = ~last_grant;
    else                 grant = elig_d;
  end

  assign arvalid       = (state == ST_AR_SEND);
  assign arsize        = 3'b010;
  assign arburst       = 2'b01;
  assign arlock        = 2'b00;
  assign arcache       = 4'b0000;
  assign arprot        = 3'b000;
  assign ar_hs         = arvalid & arready;
  assign icache_rd_rdy = ar_hs & ~arid[0];
  assign dcache_rd_rdy = ar_hs &  arid[0];
  assign rready        = 1'b1;
  assign r_hs          = rvalid & rready;

  // AR request stage: the winner is latched on entry to AR_SEND and held until arready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      arid       <= 4'd0;
      araddr     <= 32'd0;
      arlen      <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig_i | elig_d) begin
            state  <= ST_AR_SEND;
            arid   <= {3'b000, grant};
            araddr <= grant ? dcache_rd_addr : icache_rd_addr;
            arlen  <= burst_len(grant ? dcache_rd_type : icache_rd_type);
          end
        end
        ST_AR_SEND: begin
          if (arready) begin
            state      <= ST_IDLE;
            last_grant <= arid[0];
          end
        end
      endcase
    end
  end

  // An AR handshake for one ID and an rlast for the other can land on the same edge.
  always_comb begin
    busy_nxt = busy;
    if (r_hs & rlast) busy_nxt[rid[0]] = 1'b0;
    if (ar_hs)        busy_nxt[arid[0]] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) busy <= 2'b00;
    else          busy <= busy_nxt;
  end

  // R return stage p1: beats for an ID with nothing outstanding are dropped here.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ret_vld_p1  <= 1'b0;
      ret_id_p1   <= 1'b0;
      ret_last_p1 <= 1'b0;
      ret_data_p1 <= 32'd0;
      rd_err      <= 1'b0;
    end else begin
      rd_err     <= rd_err | (rvalid & (rresp != 2'b00));
      ret_vld_p1 <= r_hs & busy[rid[0]];
      if (r_hs) begin
        ret_id_p1   <= rid[0];
        ret_last_p1 <= rlast;
        ret_data_p1 <= rdata;
      end
    end
  end

  assign icache_ret_valid = ret_vld_p1 & ~ret_id_p1;
  assign dcache_ret_valid = ret_vld_p1 &  ret_id_p1;
  assign icache_ret_last  = icache_ret_valid & ret_last_p1;
  assign dcache_ret_last  = dcache_ret_valid & ret_last_p1;
  assign icache_ret_data  = ret_data_p1;
  assign dcache_ret_data  = ret_data_p1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level slave/requester model.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        aresetn;
  logic        icache_rd_req;
  logic [2:0]  icache_rd_type;
  logic [31:0] icache_rd_addr;
  logic        icache_rd_rdy;
  logic        icache_ret_valid;
  logic        icache_ret_last;
  logic [31:0] icache_ret_data;
  logic        dcache_rd_req;
  logic [2:0]  dcache_rd_type;
  logic [31:0] dcache_rd_addr;
  logic        dcache_rd_rdy;
  logic        dcache_ret_valid;
  logic        dcache_ret_last;
  logic [31:0] dcache_ret_data;
  logic        wr_pending;
  logic [31:0] wr_addr;
  logic        rd_err;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks;
  int failures;

  axi_rd_arbiter #(.LINE_OFF(4), .BURST_BEATS(4)) dut (
    .aclk(clk), .aresetn(aresetn),
    .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
    .icache_ret_last(icache_ret_last), .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_last(dcache_ret_last), .dcache_ret_data(dcache_ret_data),
    .wr_pending(wr_pending), .wr_addr(wr_addr), .rd_err(rd_err),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge drive; returns the ID whose rdy is seen, -1 on timeout.
  task automatic wait_rdy(input string tag, output int id);
    id = -1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (icache_rd_rdy) begin id = 0; break; end
      if (dcache_rd_rdy) begin id = 1; break; end
      @(negedge clk); #1;
    end
    chk({tag, "_timeout"}, 32'(id >= 0), 1);
  endtask

  // Randomized-phase model state
  logic        m_req   [2];
  logic [31:0] m_addr  [2];
  logic [2:0]  m_type  [2];
  logic        m_out   [2];
  int          m_rem   [2];
  logic        got_rdy [2];
  int          wait_cnt[2];
  int          max_wait;
  int          grants;
  logic        m_err;
  logic        prev_v, prev_id, prev_l;
  logic [31:0] prev_d;
  logic        cur_v, cur_id, cur_l, cur_bad;
  logic [31:0] cur_d;

  int t5_id   [5] = '{0, 1, 0, 0, 0};
  int t5_last [5] = '{0, 1, 0, 0, 1};
  int t5_resp [5] = '{0, 2, 0, 0, 0};

  initial begin
    int id;
    int cand;
    logic rdy_i;
    logic [7:0] exp_len;
    checks = 0; failures = 0;
    aresetn = 1'b0;
    icache_rd_req = 0; icache_rd_type = 0; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_type = 0; dcache_rd_addr = 0;
    wr_pending = 0; wr_addr = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_arid", 32'(arid), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", 32'(arlen), 0);
    chk("rst_arsize", 32'(arsize), 2);
    chk("rst_arburst", 32'(arburst), 1);
    chk("rst_lock_cache_prot", 32'({arlock, arcache, arprot}), 0);
    chk("rst_rdy", 32'({icache_rd_rdy, dcache_rd_rdy}), 0);
    chk("rst_ret", 32'({icache_ret_valid, icache_ret_last, dcache_ret_valid, dcache_ret_last}), 0);
    chk("rst_ret_data", icache_ret_data, 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_rready", 32'(rready), 1);

    @(negedge clk); aresetn = 1'b1;

    // Test 1: dcache line burst
    @(negedge clk);
    dcache_rd_req = 1; dcache_rd_type = 3'b100; dcache_rd_addr = 32'h1C00_0040; arready = 1;
    #1; chk("t1_idle_arvalid", 32'(arvalid), 0);
    @(negedge clk); #1;
    chk("t1_arvalid", 32'(arvalid), 1);
    chk("t1_arid", 32'(arid), 1);
    chk("t1_arlen", 32'(arlen), 3);
    chk("t1_araddr", araddr, 32'h1C00_0040);
    chk("t1_d_rdy", 32'(dcache_rd_rdy), 1);
    chk("t1_i_rdy", 32'(icache_rd_rdy), 0);
    @(negedge clk); dcache_rd_req = 0; #1;
    chk("t1_rdy_pulse", 32'(dcache_rd_rdy), 0);
    chk("t1_arvalid_drop", 32'(arvalid), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rvalid = 1; rid = 4'd1; rdata = 32'(32'hA0 + k); rlast = (k == 3); rresp = 0;
      #1;
      if (k > 0) begin
        chk("t1_ret_valid", 32'(dcache_ret_valid), 1);
        chk("t1_ret_data", dcache_ret_data, 32'(32'hA0 + k - 1));
        chk("t1_ret_last", 32'(dcache_ret_last), 0);
        chk("t1_i_ret_valid", 32'(icache_ret_valid), 0);
      end
    end
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("t1_ret_valid_last", 32'(dcache_ret_valid), 1);
    chk("t1_ret_data_last", dcache_ret_data, 32'hA3);
    chk("t1_ret_last_last", 32'(dcache_ret_last), 1);
    @(negedge clk); #1;
    chk("t1_ret_idle", 32'(dcache_ret_valid), 0);

    // Test 2: simultaneous requests alternate
    @(negedge clk);
    icache_rd_req = 1; icache_rd_type = 0; icache_rd_addr = 32'h1C00_0100;
    dcache_rd_req = 1; dcache_rd_type = 0; dcache_rd_addr = 32'h1C00_0200;
    for (int g = 0; g < 4; g++) begin
      wait_rdy("t2_grant", id);
      chk("t2_grant_order", 32'(id), 32'(g % 2));
      @(negedge clk);
      if (g == 3) begin icache_rd_req = 0; dcache_rd_req = 0; end
      rvalid = 1; rid = 4'(id); rdata = 32'(32'h100 + g); rlast = 1;
      @(negedge clk); rvalid = 0; rlast = 0; #1;
      chk("t2_ret", 32'((id == 0) ? icache_ret_valid : dcache_ret_valid), 1);
      chk("t2_ret_data", (id == 0) ? icache_ret_data : dcache_ret_data, 32'(32'h100 + g));
    end
    @(negedge clk); #1;
    chk("t2_quiet", 32'(arvalid), 0);

    // Test 3: read-after-write hazard on dcache line
    @(negedge clk);
    wr_pending = 1; wr_addr = 32'h1C00_0044;
    dcache_rd_req = 1; dcache_rd_type = 0; dcache_rd_addr = 32'h1C00_0040;
    icache_rd_req = 1; icache_rd_type = 0; icache_rd_addr = 32'h1C00_1000;
    wait_rdy("t3_icache", id);
    chk("t3_first_grant", 32'(id), 0);
    @(negedge clk); icache_rd_req = 0; rvalid = 1; rid = 4'd0; rdata = 32'h333; rlast = 1;
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("t3_i_ret", 32'(icache_ret_valid), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t3_hazard_block", 32'({arvalid, dcache_rd_rdy}), 0);
    end
    @(negedge clk); wr_pending = 0; #1;
    chk("t3_release_lat", 32'(arvalid), 0);
    @(negedge clk); #1;
    chk("t3_arvalid", 32'(arvalid), 1);
    chk("t3_d_rdy", 32'(dcache_rd_rdy), 1);
    chk("t3_araddr", araddr, 32'h1C00_0040);
    @(negedge clk); dcache_rd_req = 0; rvalid = 1; rid = 4'd1; rdata = 32'h444; rlast = 1;
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("t3_d_ret", 32'(dcache_ret_valid), 1);
    chk("t3_d_ret_data", dcache_ret_data, 32'h444);

    // Test 4: AR stall keeps fields stable
    @(negedge clk);
    arready = 0;
    icache_rd_req = 1; icache_rd_type = 3'b100; icache_rd_addr = 32'h1C00_2000;
    dcache_rd_req = 1; dcache_rd_type = 3'b000; dcache_rd_addr = 32'h1C00_3000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t4_arvalid", 32'(arvalid), 1);
      chk("t4_arid", 32'(arid), 0);
      chk("t4_araddr", araddr, 32'h1C00_2000);
      chk("t4_arlen", 32'(arlen), 3);
      chk("t4_no_rdy", 32'({icache_rd_rdy, dcache_rd_rdy}), 0);
    end
    @(negedge clk); arready = 1; #1;
    chk("t4_i_rdy", 32'(icache_rd_rdy), 1);
    @(negedge clk); icache_rd_req = 0; #1;
    chk("t4_rdy_pulse", 32'(icache_rd_rdy), 0);
    wait_rdy("t4_dc", id);
    chk("t4_dc_grant", 32'(id), 1);
    chk("t4_dc_arlen", 32'(arlen), 0);
    @(negedge clk); dcache_rd_req = 0;

    // Test 5: interleaved returns and error response
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rvalid = 1; rid = 4'(t5_id[k]); rdata = 32'(32'h500 + k);
      rlast = (t5_last[k] != 0); rresp = 2'(t5_resp[k]);
      #1;
      if (k > 0) begin
        chk("t5_i_valid", 32'(icache_ret_valid), 32'(t5_id[k-1] == 0));
        chk("t5_d_valid", 32'(dcache_ret_valid), 32'(t5_id[k-1] == 1));
        chk("t5_data", (t5_id[k-1] == 0) ? icache_ret_data : dcache_ret_data, 32'(32'h500 + k - 1));
        chk("t5_last", 32'((t5_id[k-1] == 0) ? icache_ret_last : dcache_ret_last), 32'(t5_last[k-1]));
      end
      if (k == 2) chk("t5_rd_err_set", 32'(rd_err), 1);
    end
    @(negedge clk); rvalid = 0; rlast = 0; rresp = 0; #1;
    chk("t5_i_valid_end", 32'(icache_ret_valid), 1);
    chk("t5_i_last_end", 32'(icache_ret_last), 1);
    chk("t5_data_end", icache_ret_data, 32'h504);
    @(negedge clk); #1;
    chk("t5_quiet", 32'({icache_ret_valid, dcache_ret_valid}), 0);
    chk("t5_rd_err_sticky", 32'(rd_err), 1);

    // Test 6: reset in the middle of an icache burst
    @(negedge clk);
    icache_rd_req = 1; icache_rd_type = 3'b100; icache_rd_addr = 32'h1C00_4000;
    wait_rdy("t6_grant", id);
    chk("t6_grant_id", 32'(id), 0);
    @(negedge clk); icache_rd_req = 0; rvalid = 1; rid = 4'd0; rdata = 32'h600; rlast = 0;
    @(negedge clk); rdata = 32'h601; #1;
    chk("t6_beat0", 32'(icache_ret_valid), 1);
    @(negedge clk); rvalid = 0; #1;
    chk("t6_beat1", icache_ret_data, 32'h601);
    @(negedge clk); aresetn = 0;
    @(negedge clk); aresetn = 1; #1;
    chk("t6_rst_ret", 32'({icache_ret_valid, dcache_ret_valid}), 0);
    chk("t6_rst_rd_err", 32'(rd_err), 0);
    chk("t6_rst_arvalid", 32'(arvalid), 0);
    @(negedge clk); rvalid = 1; rid = 4'd0; rdata = 32'h602; rlast = 0;
    @(negedge clk); rdata = 32'h603; rlast = 1; #1;
    chk("t6_stale_beat2", 32'(icache_ret_valid), 0);
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("t6_stale_beat3", 32'({icache_ret_valid, icache_ret_last}), 0);
    @(negedge clk);
    icache_rd_req = 1; icache_rd_type = 3'b000; icache_rd_addr = 32'h1C00_5000;
    wait_rdy("t6_regrant", id);
    chk("t6_regrant_id", 32'(id), 0);
    chk("t6_regrant_addr", araddr, 32'h1C00_5000);
    @(negedge clk); icache_rd_req = 0; rvalid = 1; rid = 4'd0; rdata = 32'h604; rlast = 1;
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    chk("t6_ret_valid", 32'(icache_ret_valid), 1);
    chk("t6_ret_data", icache_ret_data, 32'h604);
    chk("t6_ret_last", 32'(icache_ret_last), 1);

    // Randomized run: requesters, AR backpressure and an interleaving R slave
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_addr[i] = 0; m_type[i] = 0; m_out[i] = 0; m_rem[i] = 0;
      got_rdy[i] = 0; wait_cnt[i] = 0;
    end
    max_wait = 0; grants = 0; m_err = 0;
    prev_v = 0; prev_id = 0; prev_l = 0; prev_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (got_rdy[i]) m_req[i] = 0;
        got_rdy[i] = 0;
        if (cyc < 2500 && !m_req[i] && $urandom_range(0, 4) == 0) begin
          m_req[i]  = 1;
          m_addr[i] = $urandom;
          m_type[i] = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
        end
      end
      icache_rd_req = m_req[0]; icache_rd_addr = m_addr[0]; icache_rd_type = m_type[0];
      dcache_rd_req = m_req[1]; dcache_rd_addr = m_addr[1]; dcache_rd_type = m_type[1];
      arready = ($urandom_range(0, 3) != 0);
      cand = -1;
      if (m_rem[0] > 0) cand = 0;
      if (m_rem[1] > 0 && (cand < 0 || $urandom_range(0, 1) == 1)) cand = 1;
      cur_v = 0; cur_id = 0; cur_l = 0; cur_bad = 0; cur_d = 0;
      if (cand >= 0 && $urandom_range(0, 2) != 0) begin
        cur_v = 1; cur_id = 1'(cand); cur_d = $urandom;
        cur_l = (m_rem[cand] == 1); cur_bad = ($urandom_range(0, 15) == 0);
        m_rem[cand] = m_rem[cand] - 1;
      end
      rvalid = cur_v; rid = {3'($urandom_range(0, 7)), cur_id}; rdata = cur_d;
      rlast = cur_l; rresp = cur_bad ? 2'b10 : 2'b00;
      #1;
      chk("rnd_i_ret_valid", 32'(icache_ret_valid), 32'(prev_v && prev_id == 0));
      chk("rnd_d_ret_valid", 32'(dcache_ret_valid), 32'(prev_v && prev_id == 1));
      if (prev_v) begin
        chk("rnd_ret_data", (prev_id == 0) ? icache_ret_data : dcache_ret_data, prev_d);
        chk("rnd_ret_last", 32'((prev_id == 0) ? icache_ret_last : dcache_ret_last), 32'(prev_l));
      end
      chk("rnd_rd_err", 32'(rd_err), 32'(m_err));
      chk("rnd_rdy_hs", 32'(icache_rd_rdy) + 32'(dcache_rd_rdy), 32'(arvalid & arready));
      for (int i = 0; i < 2; i++) begin
        rdy_i = (i == 0) ? icache_rd_rdy : dcache_rd_rdy;
        if (rdy_i) begin
          exp_len = (m_type[i] == 3'b100) ? 8'd3 : 8'd0;
          chk("rnd_arid", 32'(arid), 32'(i));
          chk("rnd_req_held", 32'(m_req[i]), 1);
          chk("rnd_not_outstanding", 32'(m_out[i]), 0);
          chk("rnd_araddr", araddr, m_addr[i]);
          chk("rnd_arlen", 32'(arlen), 32'(exp_len));
          m_out[i] = 1; m_rem[i] = int'(exp_len) + 1; got_rdy[i] = 1; grants++;
        end
        if (m_req[i] && !rdy_i) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      m_err = m_err | (cur_v & cur_bad);
      if (cur_v && cur_l) m_out[cur_id] = 0;
      prev_v = cur_v; prev_id = cur_id; prev_l = cur_l; prev_d = cur_d;
    end
    chk("rnd_max_wait_bounded", 32'(max_wait <= 300), 1);
    chk("rnd_grants_made", 32'(grants > 100), 1);
    chk("rnd_drained", 32'({m_req[0], m_req[1], m_out[0], m_out[1]}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
